compara_tiros_asteroides_multi: RTL and testbench

Parametrised collision-sweep engine for shots vs. asteroids. On a start pulse it scans every asteroid slot and, for each live asteroid, every shot slot, reading both memories through synchronous read ports. A shot–asteroid pair collides when the shot is within a programmable radius of the asteroid. On a collision it marks the asteroid destroyed and frees the shot in the same cycle, and it counts hits per pass. It sits between the game control unit and the asteroid/shot memories, and replaces the fixed-size comparator unit.

---
 rtl/compara_tiros_asteroides_multi_pkg.sv | 25 ++
 rtl/compara_tiros_asteroides_multi_detector.sv | 19 +
 rtl/compara_tiros_asteroides_multi.sv | 107 ++++++++++
 tb/tb_compara_tiros_asteroides_multi.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/compara_tiros_asteroides_multi_pkg.sv
// compara_pkg: sweep FSM states, default width constants and width helper functions
package compara_pkg;
  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    LE_ASTE     = 3'd1,
    AVALIA_ASTE = 3'd2,
    LE_TIRO     = 3'd3,
    COMPARA     = 3'd4,
    DESTROI     = 3'd5,
    PROX_ASTE   = 3'd6,
    FIM         = 3'd7
  } estado_t;
  function automatic int aw_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int sat_of(input int w);
    return (1 << w) - 1;
  endfunction
  localparam int DEF_N_ASTE  = 8;
  localparam int DEF_N_TIROS = 8;
  localparam int DEF_HIT_W   = 4;
  localparam int ASTE_AW     = aw_of(DEF_N_ASTE);
  localparam int TIRO_AW     = aw_of(DEF_N_TIROS);
  localparam int HIT_SAT     = sat_of(DEF_HIT_W);
endpackage

// File: rtl/compara_tiros_asteroides_multi_detector.sv
// detector_proximidade: hit when shot is loaded and within RAIO of the asteroid on both axes (aste_x/y, tiro_x/y, tiro_loaded -> hit)
module detector_proximidade #(
  parameter int COORD_W = 4,
  parameter int RAIO    = 0
) (
  input  logic [COORD_W-1:0] aste_x,
  input  logic [COORD_W-1:0] aste_y,
  input  logic [COORD_W-1:0] tiro_x,
  input  logic [COORD_W-1:0] tiro_y,
  input  logic               tiro_loaded,
  output logic               hit
);
  logic [COORD_W-1:0] dx, dy;
  always_comb begin
    dx  = aste_x >= tiro_x ? aste_x - tiro_x : tiro_x - aste_x;
    dy  = aste_y >= tiro_y ? aste_y - tiro_y : tiro_y - aste_y;
    hit = tiro_loaded && int'(dx) <= RAIO && int'(dy) <= RAIO;
  end
endmodule

// File: rtl/compara_tiros_asteroides_multi.sv
// compara_tiros_asteroides_multi: shot-vs-asteroid sweep (iniciar -> scans memories via aste_/tiro_ ports, writes kills, reports fim/acertos)
module compara_tiros_asteroides_multi
  import compara_pkg::*;
#(
  parameter int N_ASTE  = 8,
  parameter int N_TIROS = 8,
  parameter int COORD_W = 4,
  parameter int RAIO    = 0,
  parameter int HIT_W   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        iniciar,
  output logic [aw_of(N_ASTE)-1:0]    aste_addr,
  input  logic [COORD_W-1:0]          aste_x,
  input  logic [COORD_W-1:0]          aste_y,
  input  logic                        aste_loaded,
  input  logic                        aste_destruido,
  output logic                        aste_we,
  output logic                        aste_wloaded,
  output logic                        aste_wdestruido,
  output logic [aw_of(N_TIROS)-1:0]   tiro_addr,
  input  logic [COORD_W-1:0]          tiro_x,
  input  logic [COORD_W-1:0]          tiro_y,
  input  logic                        tiro_loaded,
  output logic                        tiro_we,
  output logic                        tiro_wloaded,
  output logic                        ocupado,
  output logic                        fim,
  output logic [HIT_W-1:0]            acertos,
  output logic [3:0]                  db_estado
);
  localparam int AW = aw_of(N_ASTE);
  localparam int TW = aw_of(N_TIROS);
  localparam logic [AW-1:0] IA_LAST = AW'(N_ASTE - 1);
  localparam logic [TW-1:0] IT_LAST = TW'(N_TIROS - 1);
  estado_t estado;
  logic [AW-1:0] ia;
  logic [TW-1:0] it;
  logic hit;
  detector_proximidade #(.COORD_W(COORD_W), .RAIO(RAIO)) u_det (
    .aste_x(aste_x), .aste_y(aste_y), .tiro_x(tiro_x), .tiro_y(tiro_y),
    .tiro_loaded(tiro_loaded), .hit(hit)
  );
  // counters drive the memory addresses directly, so they stay put between counter steps
  assign aste_addr       = ia;
  assign tiro_addr       = it;
  assign aste_wloaded    = 1'b0;
  assign aste_wdestruido = 1'b1;
  assign tiro_wloaded    = 1'b0;
  assign db_estado       = {1'b0, estado};
  // strobes and fim are set on the transition into their state so they line up with it
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      estado  <= OCIOSO;
      ia      <= '0;
      it      <= '0;
      acertos <= '0;
      aste_we <= 1'b0;
      tiro_we <= 1'b0;
      fim     <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      aste_we <= 1'b0;
      tiro_we <= 1'b0;
      fim     <= 1'b0;
      case (estado)
        OCIOSO: if (iniciar) begin
          estado  <= LE_ASTE;
          ia      <= '0;
          acertos <= '0;
          ocupado <= 1'b1;
        end
        LE_ASTE: estado <= AVALIA_ASTE;
        AVALIA_ASTE: if (aste_loaded && !aste_destruido) begin
          estado <= LE_TIRO;
          it     <= '0;
        end else estado <= PROX_ASTE;
        LE_TIRO: estado <= COMPARA;
        COMPARA: if (hit) begin
          estado  <= DESTROI;
          aste_we <= 1'b1;
          tiro_we <= 1'b1;
        end else if (it == IT_LAST) estado <= PROX_ASTE;
        else begin
          it     <= it + 1'b1;
          estado <= LE_TIRO;
        end
        DESTROI: begin
          acertos <= &acertos ? acertos : acertos + 1'b1;
          estado  <= PROX_ASTE;
        end
        PROX_ASTE: if (ia == IA_LAST) begin
          estado <= FIM;
          fim    <= 1'b1;
        end else begin
          ia     <= ia + 1'b1;
          estado <= LE_ASTE;
        end
        FIM: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
        default: estado <= OCIOSO;
      endcase
    end
endmodule

// File: tb/tb_compara_tiros_asteroides_multi.sv
// tb_compara_tiros_asteroides_multi: directed checks of three sweep configurations sharing one memory model
module tb_compara_tiros_asteroides_multi;
  logic clock = 1'b0, reset = 1'b1, ld = 1'b0;
  int sel = 0, tests = 0, fails = 0, nwe = 0, wa = 0, wt = 0, wok = 0;
  logic [3:0] sx[4], sy[4], stx[4], sty[4], mx[4], my[4], mtx[4], mty[4];
  logic sl[4], sd[4], stl[4], ml[4], md[4], mtl[4];
  logic ini[3];
  logic [1:0] aa[3], ta[3];
  logic awe[3], awl[3], awd[3], twe[3], twl[3], ocp[3], fimv[3];
  logic [3:0] dbe[3], acv[3];
  always #5 clock = ~clock;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int R  = g == 1 ? 1 : 0;
    localparam int HW = g == 2 ? 1 : 4;
    logic [3:0] rax, ray, rtx, rty;
    logic ral, rad, rtl;
    logic [HW-1:0] ac;
    always @(posedge clock) begin
      rax <= mx[aa[g]]; ray <= my[aa[g]]; ral <= ml[aa[g]]; rad <= md[aa[g]];
      rtx <= mtx[ta[g]]; rty <= mty[ta[g]]; rtl <= mtl[ta[g]];
    end
    compara_tiros_asteroides_multi #(.N_ASTE(4), .N_TIROS(4), .COORD_W(4), .RAIO(R), .HIT_W(HW)) dut (
      .clock(clock), .reset(reset), .iniciar(ini[g]),
      .aste_addr(aa[g]), .aste_x(rax), .aste_y(ray), .aste_loaded(ral), .aste_destruido(rad),
      .aste_we(awe[g]), .aste_wloaded(awl[g]), .aste_wdestruido(awd[g]),
      .tiro_addr(ta[g]), .tiro_x(rtx), .tiro_y(rty), .tiro_loaded(rtl),
      .tiro_we(twe[g]), .tiro_wloaded(twl[g]),
      .ocupado(ocp[g]), .fim(fimv[g]), .acertos(ac), .db_estado(dbe[g])
    );
    assign acv[g] = 4'(ac);
  end
  always @(posedge clock)
    if (ld) for (int i = 0; i < 4; i++) begin
      mx[i] <= sx[i]; my[i] <= sy[i]; ml[i] <= sl[i]; md[i] <= sd[i];
      mtx[i] <= stx[i]; mty[i] <= sty[i]; mtl[i] <= stl[i];
    end else begin
      if (awe[sel]) begin ml[aa[sel]] <= awl[sel]; md[aa[sel]] <= awd[sel]; end
      if (twe[sel]) mtl[ta[sel]] <= twl[sel];
    end
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      sx[i] = 0; sy[i] = 0; sl[i] = 0; sd[i] = 0; stx[i] = 0; sty[i] = 0; stl[i] = 0;
    end
  endtask
  task automatic ast(input int i, input int x, input int y, input bit d);
    sx[i] = 4'(x); sy[i] = 4'(y); sl[i] = 1'b1; sd[i] = d;
  endtask
  task automatic tiro(input int i, input int x, input int y);
    stx[i] = 4'(x); sty[i] = 4'(y); stl[i] = 1'b1;
  endtask
  task automatic load();
    ld = 1'b1;
    @(posedge clock); #1;
    ld = 1'b0;
  endtask
  task automatic run(input int s, input int exp_lat, input string tag);
    int n;
    bit done;
    sel = s; n = 0; done = 0; nwe = 0; wok = 0;
    ini[s] = 1'b1;
    while (!done && n < 400) begin
      @(posedge clock); #1;
      n++;
      ini[s] = 1'b0;
      if (awe[s]) begin
        nwe++; wa = aa[s]; wt = ta[s];
        wok = int'(awd[s] & ~awl[s] & twe[s] & ~twl[s]);
      end
      if (fimv[s]) done = 1;
    end
    chk({tag, " latency"}, n, exp_lat);
  endtask
  initial begin
    int n;
    for (int g = 0; g < 3; g++) ini[g] = 1'b0;
    clr();
    ld = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    ld = 1'b0;
    chk("reset state", int'(dbe[0]), 0);
    chk("reset ocupado", int'(ocp[0]), 0);
    chk("reset addr", int'(aa[0]) + int'(ta[0]), 0);
    reset = 1'b0;
    @(posedge clock); #1;
    run(0, 13, "empty");
    chk("empty strobes", nwe, 0);
    chk("empty acertos", int'(acv[0]), 0);
    clr(); ast(2, 5, 7, 0); tiro(3, 5, 7); load();
    run(0, 22, "exact");
    chk("exact strobes", nwe, 1);
    chk("exact aste addr", wa, 2);
    chk("exact tiro addr", wt, 3);
    chk("exact wdata", wok, 1);
    chk("exact acertos", int'(acv[0]), 1);
    chk("exact mem", int'({ml[2], md[2], mtl[3]}), 3'b010);
    clr(); load();
    chk("acertos held", int'(acv[0]), 1);
    clr(); ast(0, 0, 0, 0); tiro(0, 1, 1); load();
    run(1, 16, "raio diag");
    chk("raio diag acertos", int'(acv[1]), 1);
    clr(); ast(0, 0, 0, 0); tiro(0, 2, 0); load();
    run(1, 21, "raio far");
    chk("raio far strobes", nwe, 0);
    clr(); ast(0, 15, 15, 0); tiro(0, 0, 0); load();
    run(1, 21, "no wrap");
    chk("no wrap acertos", int'(acv[1]), 0);
    clr(); ast(0, 3, 3, 0); ast(1, 3, 3, 0); tiro(0, 3, 3); load();
    run(0, 24, "shared");
    chk("shared strobes", nwe, 1);
    chk("shared acertos", int'(acv[0]), 1);
    chk("shared ast1 alive", int'({ml[1], md[1]}), 2'b10);
    chk("shared ast0 dead", int'({ml[0], md[0]}), 2'b01);
    clr(); ast(1, 4, 4, 1); tiro(0, 4, 4); load();
    run(0, 13, "skip");
    chk("skip strobes", nwe, 0);
    chk("skip shot kept", int'(mtl[0]), 1);
    clr(); ast(0, 1, 1, 0); ast(1, 2, 2, 0); ast(2, 3, 3, 0);
    tiro(0, 1, 1); tiro(1, 2, 2); tiro(2, 3, 3); load();
    run(2, 28, "sat");
    chk("sat strobes", nwe, 3);
    chk("sat acertos", int'(acv[2]), 1);
    clr(); ast(0, 6, 6, 0); ast(1, 1, 2, 0); tiro(0, 6, 6); load();
    sel = 0; ini[0] = 1'b1;
    @(posedge clock); #1;
    ini[0] = 1'b0;
    n = 0;
    while (!(dbe[0] == 4 && aa[0] == 1 && ta[0] == 2) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("rst reach compara", int'(n < 200), 1);
    chk("rst acertos before", int'(acv[0]), 1);
    reset = 1'b1;
    #1;
    chk("rst async state", int'(dbe[0]), 0);
    @(posedge clock); #1;
    chk("rst state", int'(dbe[0]), 0);
    chk("rst outputs", int'({ocp[0], fimv[0], awe[0], twe[0], acv[0], aa[0], ta[0]}), 0);
    chk("rst ast1 alive", int'({ml[1], md[1]}), 2'b10);
    reset = 1'b0;
    clr(); load();
    sel = 0; ini[0] = 1'b1; n = 0;
    while (!fimv[0] && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    chk("held latency", n, 13);
    @(posedge clock); #1;
    chk("held idle gap", int'(ocp[0]), 0);
    @(posedge clock); #1;
    chk("held restart", int'(ocp[0]), 1);
    chk("held restart state", int'(dbe[0]), 1);
    ini[0] = 1'b0; n = 0;
    while (!fimv[0] && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    chk("held second pass", n, 12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
